c2c_slave_ctrl: RTL and testbench

//   Slave-side chip2chip handshake sequencer. Synchronises the master's request/valid pins and answers with ack.

---
 rtl/c2c_pkg.sv | 21 ++
 rtl/c2c_sec_timer.sv | 31 +++
 rtl/c2c_slave_ctrl.sv | 142 ++++++++++++++
 tb/tb_c2c_slave_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/c2c_pkg.sv
// Shared definitions for the chip2chip slave: state encodings, synchroniser depth,
// default timing constants and a counter-width helper.
package c2c_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_SHOW = 2'd2,
        ST_DONE = 2'd3
    } c2c_state_t;

    localparam int SYNC_STAGES         = 2;
    localparam int DEF_SEC_CYCLES      = 100000000;
    localparam int DEF_TIMEOUT_CYCLES  = 50000000;

    // Counter width for a 0..n-1 range, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/c2c_sec_timer.sv
// Display timer: counts 0..CYCLES-1 while start is held and flags done on the last count.
// Dropping start clears the count, so every SHOW period starts from zero.
module c2c_sec_timer
    import c2c_pkg::*;
#(
    parameter int CYCLES = DEF_SEC_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic done
);

    localparam int            CW   = cnt_width(CYCLES);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [CW-1:0] count_reg;

    assign done = start && (count_reg == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (!start || done) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/c2c_slave_ctrl.sv
// Slave-side chip2chip handshake: synchronises request/valid, acknowledges, captures the word
// and lights the busy LED for SEC_CYCLES. Define C2C_TIMEOUT_EN to add the ACK-state timeout.
module c2c_slave_ctrl
    import c2c_pkg::*;
#(
    parameter int DATA_W         = 3,
    parameter int SEC_CYCLES     = DEF_SEC_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              request,
    input  logic              valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              ack,
    output logic [DATA_W-1:0] data_out,
    output logic              led_busy,
    output logic [1:0]        state_o
`ifdef C2C_TIMEOUT_EN
    ,
    output logic              timeout
`endif
);

    logic [1:0] pins;
    logic [1:0] pins_s;
    logic       req_s;
    logic       val_s;

    assign pins  = {valid, request};
    assign req_s = pins_s[0];
    assign val_s = pins_s[1];

    // One independent shift chain per asynchronous pin.
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        logic [SYNC_STAGES-1:0] chain_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                chain_reg <= '0;
            end else begin
                chain_reg <= {chain_reg[SYNC_STAGES-2:0], pins[gi]};
            end
        end

        assign pins_s[gi] = chain_reg[SYNC_STAGES-1];
    end

    c2c_state_t        state_reg;
    logic              ack_reg;
    logic              led_reg;
    logic [DATA_W-1:0] data_reg;
    logic              timer_done;

    c2c_sec_timer #(
        .CYCLES(SEC_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .start(state_reg == ST_SHOW),
        .done (timer_done)
    );

`ifdef C2C_TIMEOUT_EN
    localparam int             TW      = cnt_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0]             to_cnt_reg;
    logic                      timeout_reg;
    assign timeout = timeout_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            ack_reg     <= 1'b0;
            led_reg     <= 1'b0;
            data_reg    <= '0;
`ifdef C2C_TIMEOUT_EN
            to_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
`endif
        end else begin
`ifdef C2C_TIMEOUT_EN
            timeout_reg <= 1'b0;
`endif
            case (state_reg)
                ST_IDLE: begin
                    ack_reg <= 1'b0;
                    led_reg <= 1'b0;
                    if (req_s) begin
                        state_reg <= ST_ACK;
                        ack_reg   <= 1'b1;
`ifdef C2C_TIMEOUT_EN
                        to_cnt_reg <= '0;
`endif
                    end
                end
                ST_ACK: begin
                    // valid wins over a simultaneous request drop: the word is already on the pins.
                    if (val_s) begin
                        data_reg  <= data_in;
                        state_reg <= ST_SHOW;
                        ack_reg   <= 1'b0;
                        led_reg   <= 1'b1;
                    end else if (!req_s) begin
                        state_reg <= ST_IDLE;
                        ack_reg   <= 1'b0;
                    end
`ifdef C2C_TIMEOUT_EN
                    else if (to_cnt_reg == TO_LAST) begin
                        state_reg   <= ST_DONE;
                        ack_reg     <= 1'b0;
                        timeout_reg <= 1'b1;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
`endif
                end
                ST_SHOW: begin
                    if (timer_done) begin
                        state_reg <= ST_DONE;
                        led_reg   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    ack_reg <= 1'b0;
                    led_reg <= 1'b0;
                    if (!req_s && !val_s) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign ack      = ack_reg;
    assign led_busy = led_reg;
    assign data_out = data_reg;
    assign state_o  = state_reg;

endmodule

// File: tb/tb_c2c_slave_ctrl.sv
// Directed bench for c2c_slave_ctrl with SEC_CYCLES=10, TIMEOUT_CYCLES=8, DATA_W=3.
// Expected values are worked out by hand from the pin-to-edge timing of the handshake.
module tb_c2c_slave_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       request;
    logic       valid;
    logic [2:0] data_in;
    logic       ack;
    logic [2:0] data_out;
    logic       led_busy;
    logic [1:0] state_o;
`ifdef C2C_TIMEOUT_EN
    logic       timeout;
`endif

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    c2c_slave_ctrl #(
        .DATA_W(3),
        .SEC_CYCLES(10),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .request (request),
        .valid   (valid),
        .data_in (data_in),
        .ack     (ack),
        .data_out(data_out),
        .led_busy(led_busy),
        .state_o (state_o)
`ifdef C2C_TIMEOUT_EN
        ,
        .timeout (timeout)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Counts samples with led_busy high, starting at a sample where it is already high.
    task automatic count_led(output int cnt);
        cnt = 0;
        for (int i = 0; i < 40 && led_busy; i++) begin
            cnt++;
            step();
        end
    endtask

    initial begin
        rst_n = 1'b0; request = 1'b0; valid = 1'b0; data_in = 3'd0;
        #12;
        check("rst_ack", 32'(ack), 0);
        check("rst_led", 32'(led_busy), 0);
        check("rst_data", 32'(data_out), 0);
        check("rst_state", 32'(state_o), 0);
        #10 rst_n = 1'b1;
        steps(2);

        // Abort: request drops before valid
        request = 1'b1;
        steps(2);
        check("abort_ack_early", 32'(ack), 0);
        step();
        check("abort_ack_3rd_edge", 32'(ack), 1);
        check("abort_state_ack", 32'(state_o), 1);
        request = 1'b0;
        steps(2);
        check("abort_still_ack", 32'(state_o), 1);
        step();
        check("abort_state_idle", 32'(state_o), 0);
        check("abort_ack_low", 32'(ack), 0);
        check("abort_data_kept", 32'(data_out), 0);
        steps(2);

        // Basic transfer of 5
        request = 1'b1;
        steps(2);
        check("basic_ack_early", 32'(ack), 0);
        step();
        check("basic_ack", 32'(ack), 1);
        valid = 1'b1; data_in = 3'd5;
        steps(2);
        check("basic_wait_valid", 32'(state_o), 1);
        step();
        check("basic_state_show", 32'(state_o), 2);
        check("basic_data", 32'(data_out), 5);
        check("basic_ack_drop", 32'(ack), 0);
        count_led(n);
        check("basic_led_cycles", 32'(n), 10);
        check("basic_state_done", 32'(state_o), 3);

        // Release: pins held high keep DONE, no second capture
        data_in = 3'd7;
        steps(5);
        check("hold_state_done", 32'(state_o), 3);
        check("hold_no_capture", 32'(data_out), 5);
        check("hold_led_off", 32'(led_busy), 0);
        request = 1'b0; valid = 1'b0;
        steps(2);
        check("release_still_done", 32'(state_o), 3);
        step();
        check("release_idle", 32'(state_o), 0);
        check("release_data_kept", 32'(data_out), 5);
        steps(2);

        // Simultaneous request and valid
        request = 1'b1; valid = 1'b1; data_in = 3'd2;
        steps(3);
        check("simul_state_ack", 32'(state_o), 1);
        check("simul_ack", 32'(ack), 1);
        step();
        check("simul_state_show", 32'(state_o), 2);
        check("simul_data", 32'(data_out), 2);
        check("simul_led", 32'(led_busy), 1);

        // Asynchronous reset in the middle of SHOW
        steps(3);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ack", 32'(ack), 0);
        check("midrst_led", 32'(led_busy), 0);
        check("midrst_data", 32'(data_out), 0);
        check("midrst_state", 32'(state_o), 0);
        request = 1'b0; valid = 1'b0;
        #3 rst_n = 1'b1;
        steps(2);

        // Next transfer must get a full-length SHOW
        request = 1'b1; valid = 1'b1; data_in = 3'd6;
        steps(4);
        check("restart_state_show", 32'(state_o), 2);
        check("restart_data", 32'(data_out), 6);
        count_led(n);
        check("restart_led_cycles", 32'(n), 10);
        request = 1'b0; valid = 1'b0;
        steps(3);
        check("restart_idle", 32'(state_o), 0);
        steps(2);

        // Request held without valid
        request = 1'b1;
        steps(3);
        check("wait_ack", 32'(ack), 1);
`ifdef C2C_TIMEOUT_EN
        check("wait_timeout_idle", 32'(timeout), 0);
        n = 0;
        for (int i = 0; i < 200 && ack; i++) begin
            n++;
            step();
        end
        check("to_ack_cycles", 32'(n), 8);
        check("to_pulse", 32'(timeout), 1);
        check("to_state_done", 32'(state_o), 3);
        step();
        check("to_pulse_end", 32'(timeout), 0);
        check("to_done_hold", 32'(state_o), 3);
`else
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (ack) n++;
            step();
        end
        check("nto_ack_cycles", 32'(n), 100);
        check("nto_state_ack", 32'(state_o), 1);
`endif
        request = 1'b0;
        steps(3);
        check("final_idle", 32'(state_o), 0);
        check("final_ack", 32'(ack), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
